radio86_bus_arbiter: RTL and testbench

//  Time-slot arbiter sharing one synchronous 8-bit RAM between the KR580VM80A core and the video DMA fetcher.

---
 rtl/radio86_bus_pkg.sv | 26 ++
 rtl/radio86_slot_timer.sv | 45 ++++
 rtl/radio86_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_radio86_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/radio86_bus_pkg.sv
// Shared types and constants for the Radio-86 RAM time-slot arbiter.
// Slot kinds, hold FSM states, default widths and the legal CE-period range.
package radio86_bus_pkg;

    localparam int unsigned AW_DEFAULT  = 16;
    localparam int unsigned DIV_DEFAULT = 8;
    localparam int unsigned DIV_MIN     = 4;
    localparam int unsigned DIV_MAX     = 32;

    typedef enum logic [1:0] {
        SLOT_CPU_WR,
        SLOT_CPU_RD,
        SLOT_DMA,
        SLOT_STEP
    } slot_e;

    typedef enum logic {
        RUN,
        HOLD
    } hold_state_e;

    function automatic logic div_legal(input int unsigned div);
        return (div >= DIV_MIN) && (div <= DIV_MAX);
    endfunction

endpackage

// File: rtl/radio86_slot_timer.sv
// Free-running slot counter 0..DIV-1 with decoded strobes for slot 0,
// the CPU read slot (DIV-2) and the CPU step slot (DIV-1).
module radio86_slot_timer
    import radio86_bus_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    output logic slot_first,
    output logic slot_read,
    output logic slot_step
);

    localparam int unsigned SW = $clog2(DIV);

    if (!div_legal(DIV)) begin : g_div_range
        $error("radio86_slot_timer: DIV out of range");
    end

    logic [SW-1:0] s_q;
    logic [SW-1:0] s_d;

    always_comb begin
        s_d = s_q + 1'b1;
        if (s_q == SW'(DIV - 1)) begin
            s_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    always_comb begin
        slot_first = (s_q == '0);
        slot_read  = (s_q == SW'(DIV - 2));
        slot_step  = (s_q == SW'(DIV - 1));
    end

endmodule

// File: rtl/radio86_bus_arbiter.sv
// Time-slot arbiter sharing one synchronous RAM between the 8080 core and video DMA.
// The CPU owns a write slot (0, when pending) and a read slot (DIV-2); DMA gets the rest.
module radio86_bus_arbiter
    import radio86_bus_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT,
    parameter int unsigned AW  = AW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_out,
    input  logic          cpu_we,
    output logic          cpu_ce,
    output logic [7:0]    cpu_in,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,
    input  logic          dma_hold,
    output logic          dma_hlda,
    output logic [AW-1:0] mem_address,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);

    logic        slot_first;
    logic        slot_read;
    logic        slot_step;
    hold_state_e hold_q;
    hold_state_e hold_d;
    logic        hlda;
    slot_e       slot_kind;
    logic        ce_done_q;
    logic        ce_done_d;
    logic [7:0]  cpu_in_q;
    logic [7:0]  cpu_in_d;
    logic        rvalid_q;
    logic        rvalid_d;

    radio86_slot_timer #(.DIV(DIV)) u_slot_timer (
        .clock      (clock),
        .reset      (reset),
        .slot_first (slot_first),
        .slot_read  (slot_read),
        .slot_step  (slot_step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= RUN;
        end else begin
            hold_q <= hold_d;
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (slot_step) begin
            hold_d = dma_hold ? HOLD : RUN;
        end
    end

    always_comb begin
        hlda = (hold_q == HOLD);
    end

    // A pending CPU write wins slot 0 even while the bus is held by DMA.
    always_comb begin
        slot_kind = SLOT_DMA;
        if (slot_first && ce_done_q && cpu_we) begin
            slot_kind = SLOT_CPU_WR;
        end else if (!hlda) begin
            if (slot_read) begin
                slot_kind = SLOT_CPU_RD;
            end else if (slot_step) begin
                slot_kind = SLOT_STEP;
            end
        end
    end

    always_comb begin
        cpu_ce      = 1'b0;
        cpu_in      = cpu_in_q;
        dma_ack     = 1'b0;
        dma_rvalid  = rvalid_q;
        dma_rdata   = mem_rdata;
        dma_hlda    = hlda;
        mem_address = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        if (reset) begin
            cpu_in     = '0;
            dma_rvalid = 1'b0;
            dma_hlda   = 1'b0;
        end else begin
            case (slot_kind)
                SLOT_CPU_WR: begin
                    mem_we      = 1'b1;
                    mem_address = cpu_address;
                    mem_wdata   = cpu_out;
                end
                SLOT_CPU_RD: begin
                    mem_address = cpu_address;
                end
                default: begin
                    // The step slot doubles as a DMA slot.
                    if (slot_kind == SLOT_STEP) begin
                        cpu_ce = !dma_hold;
                        cpu_in = mem_rdata;
                    end
                    if (dma_req) begin
                        dma_ack     = 1'b1;
                        mem_address = dma_addr;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ce_done_d = ce_done_q;
        if (slot_first) begin
            ce_done_d = 1'b0;
        end
        if (cpu_ce) begin
            ce_done_d = 1'b1;
        end
        cpu_in_d = (slot_kind == SLOT_STEP) ? mem_rdata : cpu_in_q;
        rvalid_d = dma_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ce_done_q <= 1'b0;
            cpu_in_q  <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            ce_done_q <= ce_done_d;
            cpu_in_q  <= cpu_in_d;
            rvalid_q  <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_radio86_bus_arbiter.sv
// Bench for radio86_bus_arbiter: directed scenarios then random traffic, each clock
// compared against a slot-rule reference model and a behavioural RAM.
module tb_radio86_bus_arbiter;

    localparam int unsigned DIV = 8;
    localparam int unsigned AW  = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_out;
    logic          cpu_we;
    logic          cpu_ce;
    logic [7:0]    cpu_in;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic          dma_ack;
    logic          dma_rvalid;
    logic [7:0]    dma_rdata;
    logic          dma_hold;
    logic          dma_hlda;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata = 8'h00;

    logic [7:0] ram [0:65535];

    int n_tests = 0;
    int n_fail  = 0;
    int n_ce, n_we, n_ack, n_hlda;
    logic saw_ce = 1'b0;

    // Reference model state
    int unsigned m_s = 0;
    logic        m_hlda = 1'b0;
    logic        m_ce_done = 1'b0;
    logic [7:0]  m_cpu_in = 8'h00;
    logic [7:0]  m_rd = 8'h00;
    logic        m_pend = 1'b0;
    logic [7:0]  m_pend_data = 8'h00;

    always #5 clock = ~clock;

    radio86_bus_arbiter #(.DIV(DIV), .AW(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_ce      (cpu_ce),
        .cpu_in      (cpu_in),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_ack     (dma_ack),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .dma_hold    (dma_hold),
        .dma_hlda    (dma_hlda),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous RAM: data valid one clock after the address edge.
    always @(posedge clock) begin
        mem_rdata <= ram[mem_address];
        if (mem_we) ram[mem_address] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        logic       wr, rd, st, ack_e, ce_e;
        logic [7:0] cin_e, dma_now;
        wr = 1'b0; rd = 1'b0; st = 1'b0; ack_e = 1'b0; ce_e = 1'b0;
        #5;
        if (cpu_ce)   n_ce++;
        if (mem_we)   n_we++;
        if (dma_ack)  n_ack++;
        if (dma_hlda) n_hlda++;
        saw_ce = cpu_ce;
        if (reset) begin
            check("rst_ce",     32'(cpu_ce),      32'(0));
            check("rst_ack",    32'(dma_ack),     32'(0));
            check("rst_rvalid", 32'(dma_rvalid),  32'(0));
            check("rst_hlda",   32'(dma_hlda),    32'(0));
            check("rst_we",     32'(mem_we),      32'(0));
            check("rst_addr",   32'(mem_address), 32'(0));
            check("rst_cpu_in", 32'(cpu_in),      32'(0));
        end else begin
            st    = (m_s == DIV - 1);
            rd    = !m_hlda && (m_s == DIV - 2);
            wr    = (m_s == 0) && m_ce_done && cpu_we;
            ack_e = !wr && !rd && dma_req;
            ce_e  = st && !m_hlda && !dma_hold;
            if (rd) m_rd = ram[cpu_address];
            cin_e = (st && !m_hlda) ? m_rd : m_cpu_in;
            check("cpu_ce",   32'(cpu_ce),     32'(ce_e));
            check("mem_we",   32'(mem_we),     32'(wr));
            check("dma_ack",  32'(dma_ack),    32'(ack_e));
            check("dma_hlda", 32'(dma_hlda),   32'(m_hlda));
            check("rvalid",   32'(dma_rvalid), 32'(m_pend));
            check("cpu_in",   32'(cpu_in),     32'(cin_e));
            if (wr) begin
                check("wr_addr",  32'(mem_address), 32'(cpu_address));
                check("wr_wdata", 32'(mem_wdata),   32'(cpu_out));
            end else if (rd) begin
                check("rd_addr",  32'(mem_address), 32'(cpu_address));
            end else if (ack_e) begin
                check("dma_addr", 32'(mem_address), 32'(dma_addr));
            end
            if (m_pend) check("dma_rdata", 32'(dma_rdata), 32'(m_pend_data));
        end
        dma_now = ram[dma_addr];
        @(posedge clock);
        if (reset) begin
            m_s = 0; m_hlda = 1'b0; m_ce_done = 1'b0; m_cpu_in = 8'h00; m_pend = 1'b0;
        end else begin
            m_pend      = ack_e;
            m_pend_data = dma_now;
            if (st && !m_hlda) m_cpu_in = m_rd;
            if (ce_e) m_ce_done = 1'b1;
            else if (m_s == 0) m_ce_done = 1'b0;
            if (st) m_hlda = dma_hold;
            m_s = (m_s + 1) % DIV;
        end
        #1;
    endtask

    task automatic clear_counts();
        n_ce = 0; n_we = 0; n_ack = 0; n_hlda = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[16'hF800] = 8'hC3;
        reset = 1'b1; cpu_address = 16'hF800; cpu_out = 8'h00; cpu_we = 1'b0;
        dma_req = 1'b0; dma_addr = '0; dma_hold = 1'b0;
        clear_counts();
        @(posedge clock);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Plain CPU stepping, no DMA
        clear_counts();
        for (int i = 0; i < 16; i++) tick();
        check("ce_per_16", 32'(n_ce), 32'(2));
        check("we_idle", 32'(n_we), 32'(0));
        check("cpu_in_F800", 32'(cpu_in), 32'(8'hC3));

        // Single CPU write after a ce
        clear_counts();
        cpu_we = 1'b1; cpu_address = 16'h7600; cpu_out = 8'h5A;
        for (int i = 0; i < 8; i++) tick();
        cpu_we = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("write_count", 32'(n_we), 32'(1));
        check("ram_7600", 32'(ram[16'h7600]), 32'(8'h5A));
        cpu_address = 16'hF800;

        // Continuous DMA stream
        clear_counts();
        dma_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dma_addr = 16'($urandom);
            tick();
        end
        check("dma_acks", 32'(n_ack), 32'(14));

        // Hold entry, full DMA ownership, release
        clear_counts();
        dma_hold = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dma_addr = 16'($urandom);
            tick();
        end
        dma_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dma_addr = 16'($urandom);
            tick();
        end
        check("hold_cpu_in", 32'(cpu_in), 32'(8'hC3));
        for (int i = 0; i < 8; i++) begin
            dma_addr = 16'($urandom);
            tick();
        end
        check("hold_ce", 32'(n_ce), 32'(1));
        check("hold_acks", 32'(n_ack), 32'(30));
        check("hold_hlda", 32'(n_hlda), 32'(16));

        // CPU write pending as hold is raised
        clear_counts();
        dma_req = 1'b0;
        cpu_we = 1'b1; cpu_address = 16'h1234; cpu_out = 8'hA5; dma_hold = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        dma_hold = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("hw_cpu_in", 32'(cpu_in), 32'(8'hA5));
        for (int i = 0; i < 7; i++) tick();
        check("hw_writes", 32'(n_we), 32'(1));
        check("hw_hlda", 32'(n_hlda), 32'(16));
        check("hw_no_ce", 32'(n_ce), 32'(0));
        check("ram_1234", 32'(ram[16'h1234]), 32'(8'hA5));

        // Reset right after a DMA ack
        dma_req = 1'b1; dma_addr = 16'h0042;
        tick();
        reset = 1'b1; cpu_we = 1'b0;
        tick();
        dma_req = 1'b0;
        tick();
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (saw_ce) begin
                cpu_we      = 1'($urandom_range(0, 1));
                cpu_address = 16'($urandom_range(0, 63));
                cpu_out     = 8'($urandom);
            end
            dma_req  = ($urandom_range(0, 3) != 0);
            dma_addr = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) dma_hold = ~dma_hold;
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
